// File: rtl/alu_logic_seq_if.sv
// Operand/result valid-ready bundle for alu_logic_seq.
// out_zero is present only when ALU_LOGIC_ZERO_EN is defined.
interface alu_logic_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
`ifdef ALU_LOGIC_ZERO_EN
   logic             out_zero;

   modport master (
      output in_valid, in0, in1, op, out_ready,
      input  in_ready, out_valid, out, out_zero
   );
   modport slave (
      input  in_valid, in0, in1, op, out_ready,
      output in_ready, out_valid, out, out_zero
   );
`else
   modport master (
      output in_valid, in0, in1, op, out_ready,
      input  in_ready, out_valid, out
   );
   modport slave (
      input  in_valid, in0, in1, op, out_ready,
      output in_ready, out_valid, out
   );
`endif
endinterface

// File: rtl/alu_logic_seq.sv
// Multi-cycle AND/OR/XOR/NOR unit reusing one CHUNK-wide slice WIDTH/CHUNK times.
// Optional ALU_LOGIC_ZERO_EN adds a registered out_zero flag valid with out_valid.
module alu_logic_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input logic            clock,
   input logic            reset,
   alu_logic_seq_if.slave bus
);
   localparam int unsigned NUM   = WIDTH / CHUNK;
   localparam int unsigned CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("alu_logic_seq: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   res_q;
   logic [CHUNK-1:0]   a_sl;
   logic [CHUNK-1:0]   b_sl;
   logic [CHUNK-1:0]   r_sl;

   // Shared gate slice: select the current operand slice and apply the latched op
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int unsigned i = 0; i < NUM; i++) begin
         if (cnt == CNT_W'(i)) begin
            a_sl = a_q[i*CHUNK +: CHUNK];
            b_sl = b_q[i*CHUNK +: CHUNK];
         end
      end
      r_sl = '0;
      case (op_q)
         2'b00:   r_sl = a_sl & b_sl;
         2'b01:   r_sl = a_sl | b_sl;
         2'b10:   r_sl = a_sl ^ b_sl;
         2'b11:   r_sl = ~(a_sl | b_sl);
         default: r_sl = '0;
      endcase
   end

`ifdef ALU_LOGIC_ZERO_EN
   logic acc_q;
   logic zero_q;

   // acc_q collects "any result bit set" across slices of the current operation
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) acc_q <= 1'b0;
            end
            S_RUN: begin
               acc_q <= acc_q | (|r_sl);
               if (cnt == CNT_W'(NUM - 1)) zero_q <= ~(acc_q | (|r_sl));
            end
            S_DONE: begin
               if (bus.out_ready) zero_q <= 1'b0;
            end
            default: zero_q <= 1'b0;
         endcase
      end
   end

   assign bus.out_zero = zero_q;
`endif

   // Sequencer: IDLE -> RUN (NUM slice edges) -> DONE -> IDLE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         res_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.in0;
                  b_q   <= bus.in1;
                  op_q  <= bus.op;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               for (int unsigned i = 0; i < NUM; i++) begin
                  if (cnt == CNT_W'(i)) res_q[i*CHUNK +: CHUNK] <= r_sl;
               end
               if (cnt == CNT_W'(NUM - 1)) begin
                  cnt   <= '0;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Ready is held low throughout reset so nothing is accepted before release
   assign bus.in_ready  = (state == S_IDLE) && !reset;
   assign bus.out_valid = (state == S_DONE);
   assign bus.out       = res_q;

endmodule

// File: tb/tb_alu_logic_seq.sv
// Scoreboard bench for alu_logic_seq: 32/8 main instance plus 16/16 and 24/8 latency instances.
// Build with ALU_LOGIC_ZERO_EN defined to also check out_zero.
module tb_alu_logic_seq;
   localparam int NUM = 4;

   logic clock = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   alu_logic_seq_if #(.WIDTH(32)) bus ();
   alu_logic_seq_if #(.WIDTH(16)) b16 ();
   alu_logic_seq_if #(.WIDTH(24)) b24 ();

   alu_logic_seq #(.WIDTH(32), .CHUNK(8))  dut   (.clock(clock), .reset(reset), .bus(bus.slave));
   alu_logic_seq #(.WIDTH(16), .CHUNK(16)) dut16 (.clock(clock), .reset(reset), .bus(b16.slave));
   alu_logic_seq #(.WIDTH(24), .CHUNK(8))  dut24 (.clock(clock), .reset(reset), .bus(b24.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] o);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // Result consumer side: pop expected value on every output handshake
   always @(negedge clock) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
         else                   chk("sb_result", bus.out, exp_q.pop_front());
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        input int hold);
      int          n;
      int          lat;
      int          low;
      logic [31:0] held;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      bus.in0 = a; bus.in1 = b; bus.op = o; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      exp_q.push_back(model(a, b, o));
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      bus.in0 = $urandom; bus.in1 = $urandom; bus.op = 2'($urandom_range(0, 3));
      lat = 0; low = 0;
      while (!bus.out_valid && lat < 40) begin
         if (!bus.in_ready) low++;
         @(posedge clock); #1; lat++;
      end
      chk("latency", 32'(lat), 32'(NUM));
`ifdef ALU_LOGIC_ZERO_EN
      chk("out_zero", 32'(bus.out_zero), 32'(model(a, b, o) == 32'd0));
`endif
      held = bus.out;
      repeat (hold) begin
         if (!bus.in_ready) low++;
         bus.in_valid = 1'b1; bus.in0 = $urandom; bus.in1 = $urandom;
         @(posedge clock); #1;
         bus.in_valid = 1'b0;
      end
      if (hold > 0) begin
         chk("hold_out", bus.out, held);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
      end
      if (!bus.in_ready) low++;
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      chk("ready_low_cycles", 32'(low), 32'(NUM + 1 + hold));
      chk("idle_after_hs", 32'(bus.in_ready), 32'd1);
      chk("valid_after_hs", 32'(bus.out_valid), 32'd0);
   endtask

   task automatic param_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
      int          l16;
      int          l24;
      logic [31:0] m;
      m = model(a, b, o);
      b16.in0 = a[15:0]; b16.in1 = b[15:0]; b16.op = o; b16.in_valid = 1'b1;
      b24.in0 = a[23:0]; b24.in1 = b[23:0]; b24.op = o; b24.in_valid = 1'b1;
      @(posedge clock); #1;
      b16.in_valid = 1'b0; b24.in_valid = 1'b0;
      l16 = -1; l24 = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clock); #1;
         if (l16 < 0 && b16.out_valid) l16 = c;
         if (l24 < 0 && b24.out_valid) l24 = c;
      end
      chk("p16_latency", 32'(l16), 32'd1);
      chk("p24_latency", 32'(l24), 32'd3);
      chk("p16_out", 32'(b16.out), {16'd0, m[15:0]});
      chk("p24_out", 32'(b24.out), {8'd0, m[23:0]});
      b16.out_ready = 1'b1; b24.out_ready = 1'b1;
      @(posedge clock); #1;
      b16.out_ready = 1'b0; b24.out_ready = 1'b0;
      chk("p_idle", 32'({b16.in_ready, b24.in_ready}), 32'd3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.op = '0; bus.out_ready = 1'b0;
      b16.in_valid = 1'b0; b16.in0 = '0; b16.in1 = '0; b16.op = '0; b16.out_ready = 1'b0;
      b24.in_valid = 1'b0; b24.in0 = '0; b24.in1 = '0; b24.op = '0; b24.out_ready = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out", bus.out, 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;
      #1 chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

      do_op(32'hF0F0_1234, 32'hFF00_00FF, 2'b00, 0);
      do_op(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b01, 0);
      do_op(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b10, 0);
      do_op(32'hAAAA_5555, 32'h0F0F_0F0F, 2'b11, 0);
      do_op(32'h1357_9BDF, 32'hFEDC_BA98, 2'b10, 10);

      // Reset between RUN edges 2 and 3
      bus.in0 = 32'h1234_5678; bus.in1 = 32'hFFFF_FFFF; bus.op = 2'b01; bus.in_valid = 1'b1;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_out", bus.out, 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clock) reset = 1'b0;
      #1;
      do_op(32'hDEAD_BEEF, 32'h0000_FFFF, 2'b00, 0);

      param_op(32'h00C3_A5F0, 32'h0099_0F0F, 2'b10);
      param_op(32'h0012_3456, 32'h0065_4321, 2'b11);

      do_op(32'h0000_FFFF, 32'hFFFF_0000, 2'b00, 0);
      do_op(32'h0000_FFFF, 32'hFFFF_0000, 2'b01, 0);
      for (int i = 0; i < 4; i++) begin
         do_op($urandom, $urandom, 2'($urandom_range(0, 3)), i);
      end

      repeat (2) @(posedge clock);
      #1 chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
